// File: rtl/jtag_tap_target.sv
// IEEE 1149.1-style TAP target: 16-state TAP controller, instruction register,
// bypass bit, user data register and boundary-scan register, LSB-first shifting.
module jtag_tap_target #(
  parameter int         INSTRUCTION_WIDTH = 5,
  parameter int         TEST_VECTOR_WIDTH = 32,
  parameter logic [4:0] BYPASS_OPCODE     = 5'b00000,
  parameter logic [4:0] USER_OPCODE       = 5'b00001,
  parameter logic [4:0] BOUNDARY_OPCODE   = 5'b00110
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         trst,
  input  logic                         tms,
  input  logic                         tdi,
  output logic                         tdo,
  output logic                         tdoValid,
  output logic [3:0]                   tapState,
  output logic [INSTRUCTION_WIDTH-1:0] instruction,
  output logic [TEST_VECTOR_WIDTH-1:0] userRegister,
  output logic [TEST_VECTOR_WIDTH-1:0] boundaryRegister,
  output logic                         updateDrPulse
);

  localparam int IW = INSTRUCTION_WIDTH;
  localparam int TW = TEST_VECTOR_WIDTH;

  localparam logic [IW-1:0] OP_BYP     = BYPASS_OPCODE[IW-1:0];
  localparam logic [IW-1:0] OP_USR     = USER_OPCODE[IW-1:0];
  localparam logic [IW-1:0] OP_BND     = BOUNDARY_OPCODE[IW-1:0];
  localparam logic [IW-1:0] IR_CAPTURE = {{(IW-2){1'b0}}, 2'b01};

  typedef enum logic [3:0] {
    S_RESET      = 4'd0,
    S_IDLE       = 4'd1,
    S_DR_SCAN    = 4'd2,
    S_IR_SCAN    = 4'd3,
    S_CAPTURE_IR = 4'd4,
    S_SHIFT_IR   = 4'd5,
    S_EXIT1_IR   = 4'd6,
    S_PAUSE_IR   = 4'd7,
    S_EXIT2_IR   = 4'd8,
    S_UPDATE_IR  = 4'd9,
    S_CAPTURE_DR = 4'd10,
    S_SHIFT_DR   = 4'd11,
    S_EXIT1_DR   = 4'd12,
    S_PAUSE_DR   = 4'd13,
    S_EXIT2_DR   = 4'd14,
    S_UPDATE_DR  = 4'd15
  } tap_state_t;

  tap_state_t    r_state;
  tap_state_t    w_next;
  logic [IW-1:0] r_instruction;
  logic [IW-1:0] r_ir_shift;
  logic [TW-1:0] r_user;
  logic [TW-1:0] r_user_shift;
  logic [TW-1:0] r_bnd;
  logic [TW-1:0] r_bnd_shift;
  logic          r_bypass;
  logic          r_tdo;
  logic          r_tdo_valid;
  logic          r_upd_pulse;
  logic          w_sel_user;
  logic          w_sel_bnd;

  // Any opcode other than USER or BOUNDARY routes the DR path through bypass.
  assign w_sel_user = (r_instruction == OP_USR);
  assign w_sel_bnd  = (r_instruction == OP_BND);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_RESET;
    end else if (!trst) begin
      r_state <= S_RESET;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_RESET:      w_next = tms ? S_RESET    : S_IDLE;
      S_IDLE:       w_next = tms ? S_DR_SCAN  : S_IDLE;
      S_DR_SCAN:    w_next = tms ? S_IR_SCAN  : S_CAPTURE_DR;
      S_IR_SCAN:    w_next = tms ? S_RESET    : S_CAPTURE_IR;
      S_CAPTURE_IR: w_next = tms ? S_EXIT1_IR : S_SHIFT_IR;
      S_SHIFT_IR:   w_next = tms ? S_EXIT1_IR : S_SHIFT_IR;
      S_EXIT1_IR:   w_next = tms ? S_UPDATE_IR : S_PAUSE_IR;
      S_PAUSE_IR:   w_next = tms ? S_EXIT2_IR : S_PAUSE_IR;
      S_EXIT2_IR:   w_next = tms ? S_UPDATE_IR : S_SHIFT_IR;
      S_UPDATE_IR:  w_next = tms ? S_DR_SCAN  : S_IDLE;
      S_CAPTURE_DR: w_next = tms ? S_EXIT1_DR : S_SHIFT_DR;
      S_SHIFT_DR:   w_next = tms ? S_EXIT1_DR : S_SHIFT_DR;
      S_EXIT1_DR:   w_next = tms ? S_UPDATE_DR : S_PAUSE_DR;
      S_PAUSE_DR:   w_next = tms ? S_EXIT2_DR : S_PAUSE_DR;
      S_EXIT2_DR:   w_next = tms ? S_UPDATE_DR : S_SHIFT_DR;
      S_UPDATE_DR:  w_next = tms ? S_DR_SCAN  : S_IDLE;
      default:      w_next = S_RESET;
    endcase
  end

  // TAP reset keeps the parallel DRs and tdo; only the scan path is cleared.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_instruction <= OP_BYP;
      r_ir_shift    <= {IW{1'b0}};
      r_user        <= {TW{1'b0}};
      r_user_shift  <= {TW{1'b0}};
      r_bnd         <= {TW{1'b0}};
      r_bnd_shift   <= {TW{1'b0}};
      r_bypass      <= 1'b0;
      r_tdo         <= 1'b0;
      r_tdo_valid   <= 1'b0;
      r_upd_pulse   <= 1'b0;
    end else if (!trst) begin
      r_instruction <= OP_BYP;
      r_ir_shift    <= {IW{1'b0}};
      r_user_shift  <= {TW{1'b0}};
      r_bnd_shift   <= {TW{1'b0}};
      r_bypass      <= 1'b0;
      r_tdo_valid   <= 1'b0;
      r_upd_pulse   <= 1'b0;
    end else begin
      r_upd_pulse <= (r_state == S_UPDATE_DR);
      r_tdo_valid <= (r_state == S_SHIFT_IR) || (r_state == S_SHIFT_DR);
      case (r_state)
        S_CAPTURE_IR: r_ir_shift <= IR_CAPTURE;
        S_SHIFT_IR: begin
          r_ir_shift <= {tdi, r_ir_shift[IW-1:1]};
          r_tdo      <= r_ir_shift[0];
        end
        S_UPDATE_IR: r_instruction <= r_ir_shift;
        S_CAPTURE_DR: begin
          if (w_sel_user) begin
            r_user_shift <= r_user;
          end else if (w_sel_bnd) begin
            r_bnd_shift <= r_bnd;
          end else begin
            r_bypass <= 1'b0;
          end
        end
        S_SHIFT_DR: begin
          if (w_sel_user) begin
            r_user_shift <= {tdi, r_user_shift[TW-1:1]};
            r_tdo        <= r_user_shift[0];
          end else if (w_sel_bnd) begin
            r_bnd_shift <= {tdi, r_bnd_shift[TW-1:1]};
            r_tdo       <= r_bnd_shift[0];
          end else begin
            r_bypass <= tdi;
            r_tdo    <= r_bypass;
          end
        end
        S_UPDATE_DR: begin
          if (w_sel_user) begin
            r_user <= r_user_shift;
          end else if (w_sel_bnd) begin
            r_bnd <= r_bnd_shift;
          end else begin
            r_bypass <= r_bypass;
          end
        end
        default: begin
          r_tdo <= r_tdo;
        end
      endcase
    end
  end

  assign tapState         = r_state;
  assign instruction      = r_instruction;
  assign userRegister     = r_user;
  assign boundaryRegister = r_bnd;
  assign tdo              = r_tdo;
  assign tdoValid         = r_tdo_valid;
  assign updateDrPulse    = r_upd_pulse;

endmodule

// File: tb/tb_jtag_tap_target.sv
// Self-checking bench for jtag_tap_target: directed test-plan scans followed by
// randomized TMS/TDI traffic, all checked cycle by cycle against a table-driven model.
module tb_jtag_tap_target;
  localparam int IW = 5;
  localparam int TW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          trst = 1'b1;
  logic          tms = 1'b0;
  logic          tdi = 1'b0;
  logic          tdo;
  logic          tdoValid;
  logic [3:0]    tapState;
  logic [IW-1:0] instruction;
  logic [TW-1:0] userRegister;
  logic [TW-1:0] boundaryRegister;
  logic          updateDrPulse;

  jtag_tap_target dut (
    .clk(clk), .reset(reset), .trst(trst), .tms(tms), .tdi(tdi),
    .tdo(tdo), .tdoValid(tdoValid), .tapState(tapState), .instruction(instruction),
    .userRegister(userRegister), .boundaryRegister(boundaryRegister),
    .updateDrPulse(updateDrPulse)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int pulse_cnt = 0;

  // Reference model: state transitions as two lookup tables indexed by state.
  int            nxt0[16];
  int            nxt1[16];
  int            m_state;
  logic [IW-1:0] m_instr, m_ir;
  logic [TW-1:0] m_user, m_bnd, m_usr_sh, m_bnd_sh;
  logic          m_byp, m_tdo, m_tdov, m_pulse;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int dr_sel(input logic [IW-1:0] ins);
    if (ins == 5'd1) return 1;
    if (ins == 5'd6) return 2;
    return 0;
  endfunction

  task automatic model_edge();
    if (!reset) begin
      m_state = 0; m_instr = '0; m_ir = '0; m_user = '0; m_bnd = '0;
      m_usr_sh = '0; m_bnd_sh = '0; m_byp = 1'b0; m_tdo = 1'b0;
      m_tdov = 1'b0; m_pulse = 1'b0;
    end else if (!trst) begin
      m_state = 0; m_instr = '0; m_ir = '0; m_usr_sh = '0; m_bnd_sh = '0;
      m_byp = 1'b0; m_tdov = 1'b0; m_pulse = 1'b0;
    end else begin
      int sel;
      sel = dr_sel(m_instr);
      m_pulse = (m_state == 15);
      m_tdov  = (m_state == 5) || (m_state == 11);
      if (m_state == 4) m_ir = 5'b00001;
      if (m_state == 5) begin
        m_tdo = m_ir[0];
        m_ir  = (m_ir >> 1) | ({{(IW-1){1'b0}}, tdi} << (IW-1));
      end
      if (m_state == 9) m_instr = m_ir;
      if (m_state == 10) begin
        if (sel == 1) m_usr_sh = m_user;
        else if (sel == 2) m_bnd_sh = m_bnd;
        else m_byp = 1'b0;
      end
      if (m_state == 11) begin
        if (sel == 1) begin
          m_tdo = m_usr_sh[0];
          m_usr_sh = (m_usr_sh >> 1) | ({{(TW-1){1'b0}}, tdi} << (TW-1));
        end else if (sel == 2) begin
          m_tdo = m_bnd_sh[0];
          m_bnd_sh = (m_bnd_sh >> 1) | ({{(TW-1){1'b0}}, tdi} << (TW-1));
        end else begin
          m_tdo = m_byp;
          m_byp = tdi;
        end
      end
      if (m_state == 15) begin
        if (sel == 1) m_user = m_usr_sh;
        else if (sel == 2) m_bnd = m_bnd_sh;
      end
      m_state = tms ? nxt1[m_state] : nxt0[m_state];
    end
  endtask

  task automatic step(input logic t_ms, input logic t_di);
    tms = t_ms;
    tdi = t_di;
    @(posedge clk);
    model_edge();
    #1;
    if (updateDrPulse === 1'b1) pulse_cnt++;
    check_val("state", tapState, m_state);
    check_val("tdo", tdo, m_tdo);
    check_val("tdoValid", tdoValid, m_tdov);
    check_val("instruction", instruction, m_instr);
    check_val("userRegister", userRegister, m_user);
    check_val("boundaryRegister", boundaryRegister, m_bnd);
    check_val("updateDrPulse", updateDrPulse, m_pulse);
  endtask

  // Both scan tasks start and finish in run-test/idle.
  task automatic ir_load(input logic [IW-1:0] op);
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < IW; i++) step(i == IW-1, op[i]);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  task automatic dr_scan(input logic [TW-1:0] v, input int nbits, input int pause_at,
                         output logic [TW-1:0] got);
    got = '0;
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) begin
      step((i == nbits-1) || (i == pause_at-1), v[i]);
      got[i] = tdo;
      if ((i == pause_at-1) && (i != nbits-1)) begin
        step(1'b0, 1'($urandom)); step(1'b0, 1'($urandom)); step(1'b0, 1'($urandom));
        step(1'b1, 1'($urandom)); step(1'b0, 1'($urandom));
      end
    end
    step(1'b1, 1'b0); step(1'b0, 1'b0);
  endtask

  logic [TW-1:0] got;
  logic [TW-1:0] bv;
  logic [IW-1:0] op;
  int            pc0;

  initial begin
    nxt0 = '{1, 1, 10, 4, 5, 5, 7, 7, 5, 1, 11, 11, 13, 13, 11, 1};
    nxt1 = '{0, 2, 3, 0, 6, 6, 9, 8, 9, 2, 12, 12, 15, 14, 15, 2};

    // Reset held low for three clocks with random TMS/TDI.
    reset = 1'b0;
    for (int i = 0; i < 3; i++) step(1'($urandom), 1'($urandom));
    check_val("rst_state", tapState, 64'd0);
    check_val("rst_instr", instruction, 64'd0);
    check_val("rst_user", userRegister, 64'd0);
    check_val("rst_bnd", boundaryRegister, 64'd0);
    check_val("rst_tdov", tdoValid, 64'd0);
    check_val("rst_pulse", updateDrPulse, 64'd0);
    reset = 1'b1;

    // IR load of USER from test-logic-reset.
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    check_val("ir_shift_state", tapState, 64'd5);
    got = '0;
    for (int i = 0; i < IW; i++) begin
      step(i == IW-1, (i == 0) ? 1'b1 : 1'b0);
      got[i] = tdo;
    end
    check_val("ir_capture_tdo", got[1:0], 64'h1);
    step(1'b1, 1'b0);
    check_val("update_ir_state", tapState, 64'd9);
    step(1'b0, 1'b0);
    check_val("ir_user_loaded", instruction, 64'h01);

    // User DR write, then read back with zeros.
    pc0 = pulse_cnt;
    dr_scan(32'hA5A51234, TW, 0, got);
    check_val("user_written", userRegister, 64'hA5A51234);
    check_val("pulse_high", updateDrPulse, 64'd1);
    step(1'b0, 1'b0);
    check_val("pulse_once", pulse_cnt - pc0, 64'd1);
    dr_scan(32'h0, TW, 0, got);
    check_val("user_readback", got, 64'hA5A51234);
    dr_scan(32'hA5A51234, TW, 0, got);

    // Bypass: tdo is tdi delayed by one shifted bit.
    ir_load(5'b00000);
    dr_scan(32'h0000000D, 4, 0, got);
    check_val("bypass_tdo", got[3:0], 64'hA);
    check_val("bypass_user_kept", userRegister, 64'hA5A51234);
    check_val("bypass_bnd_kept", boundaryRegister, 64'h0);

    // Boundary write with pause after 10 bits.
    ir_load(5'b00110);
    bv = $urandom;
    dr_scan(bv, TW, 10, got);
    check_val("bnd_paused_write", boundaryRegister, {32'h0, bv});
    check_val("bnd_user_kept", userRegister, 64'hA5A51234);
    check_val("bnd_capture_zero", got, 64'h0);

    // TAP reset in the middle of a boundary shift.
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'($urandom));
    trst = 1'b0;
    step(1'b0, 1'($urandom));
    trst = 1'b1;
    check_val("trst_state", tapState, 64'd0);
    check_val("trst_instr", instruction, 64'd0);
    check_val("trst_bnd_kept", boundaryRegister, {32'h0, bv});
    step(1'b0, 1'b0);

    // Five TMS=1 from pauseIr return to test-logic-reset.
    step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    check_val("pause_ir_state", tapState, 64'd7);
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom));
    check_val("five_tms_reset", tapState, 64'd0);
    step(1'b0, 1'b0);

    // Randomized traffic checked against the model every cycle.
    for (int it = 0; it < 60; it++) begin
      int k;
      k = $urandom_range(0, 3);
      op = (k == 0) ? 5'b00000 : (k == 1) ? 5'b00001 : (k == 2) ? 5'b00110 : 5'($urandom);
      ir_load(op);
      begin
        int nb;
        nb = $urandom_range(1, TW);
        dr_scan($urandom, nb, $urandom_range(0, nb), got);
      end
      for (int c = 0; c < int'($urandom_range(0, 30)); c++) begin
        trst  = ($urandom_range(0, 49) != 0);
        reset = ($urandom_range(0, 199) != 0);
        step(($urandom_range(0, 2) == 0), 1'($urandom));
        trst  = 1'b1;
        reset = 1'b1;
      end
      for (int c = 0; c < 5; c++) step(1'b1, 1'($urandom));
      step(1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
